// File: rtl/brightness_pkg.sv
// Shared types and pixel arithmetic for the chunk write-back stage.
// Holds the FSM state encoding, lane geometry and the brightness saturation helper.
// No timing of its own; used combinationally by the write path.
package brightness_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } wb_state_t;

    localparam int LANE_W  = 16;
    localparam int N_WAVES = 7;

    // Lane is unsigned 16 b, brightness signed 9 b; the 18-bit sum cannot overflow.
    function automatic logic [7:0] sat_pixel(input logic [LANE_W-1:0] lane,
                                             input logic signed [8:0] brightness);
        logic signed [17:0] sum;
        sum = $signed({2'b00, lane}) + $signed({{9{brightness[8]}}, brightness});
        if (sum[17])
            sat_pixel = 8'd0;
        else if (sum > 18'sd255)
            sat_pixel = 8'hFF;
        else
            sat_pixel = sum[7:0];
    endfunction

endpackage

// File: rtl/deskew_buffer.sv
// 4x4 x 16 b de-skew buffer: wavefront d writes lane r into column d-3+r.
// Write takes effect on the next clock; read port is combinational.
// No flow control; the caller strobes wr_en only on accepted wavefronts.
module deskew_buffer
    import brightness_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [2:0]            wave,
    input  logic [4*LANE_W-1:0]   wave_data,
    input  logic [1:0]            rd_i,
    input  logic [1:0]            rd_j,
    output logic [LANE_W-1:0]     rd_data
);

    logic [LANE_W-1:0] mem [4][4];

    // Lanes whose diagonal column falls outside the chunk carry padding and are dropped.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (int'(wave) + r - 3 == c)
                        mem[r][c] <= wave_data[4*LANE_W-1-LANE_W*r -: LANE_W];
                end
            end
        end
    end

    assign rd_data = mem[rd_i][rd_j];

endmodule

// File: rtl/chunk_writeback.sv
// De-skews 7 wavefronts per 4x4 chunk, applies saturating brightness, writes 16 pixels to RAM.
// Latency: first write the cycle after the 7th accept; 7 accepts + 16 writes + 1 cycle per chunk.
// Backpressure: in_ready is high only while collecting; valid in any other state is ignored.
module chunk_writeback
    import brightness_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 8,
    parameter int CHUNK_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8:0]            brightness,
    input  logic [63:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int                OFF_W    = $clog2(MATRIX_SIZE) + 1;
    localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(MATRIX_SIZE - CHUNK_SIZE);
    localparam logic [OFF_W-1:0]  STEP     = OFF_W'(CHUNK_SIZE);

    wb_state_t          state;
    logic [OFF_W-1:0]   row_off;
    logic [OFF_W-1:0]   col_off;
    logic [2:0]         wave_cnt;
    logic [3:0]         pix_cnt;
    logic signed [8:0]  bright_q;

    logic                   accept;
    logic [3:0]             rd_idx;
    logic [LANE_W-1:0]      rd_data;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;

    assign accept = (state == S_COLLECT) && in_valid;

    // Outputs are registered, so the buffer is read one pixel ahead of the write cycle.
    assign rd_idx  = (state == S_WRITE) ? pix_cnt + 4'd1 : 4'd0;
    assign wr_addr = ADDR_WIDTH'((int'(row_off) + int'(rd_idx[3:2])) * MATRIX_SIZE
                                + int'(col_off) + int'(rd_idx[1:0]));
    assign wr_data = DATA_WIDTH'(sat_pixel(rd_data, bright_q));

    deskew_buffer u_buf (
        .clk       (clk),
        .wr_en     (accept),
        .wave      (wave_cnt),
        .wave_data (in_data),
        .rd_i      (rd_idx[3:2]),
        .rd_j      (rd_idx[1:0]),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            row_off   <= '0;
            col_off   <= '0;
            wave_cnt  <= '0;
            pix_cnt   <= '0;
            bright_q  <= '0;
            in_ready  <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= S_COLLECT;
                        bright_q <= brightness;
                        row_off  <= '0;
                        col_off  <= '0;
                        wave_cnt <= '0;
                        pix_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (in_valid) begin
                        wave_cnt <= wave_cnt + 3'd1;
                        if (wave_cnt == 3'(N_WAVES - 1)) begin
                            state     <= S_WRITE;
                            in_ready  <= 1'b0;
                            pix_cnt   <= '0;
                            ram_we    <= 1'b1;
                            ram_addr  <= wr_addr;
                            ram_wdata <= wr_data;
                        end
                    end
                end
                S_WRITE: begin
                    if (pix_cnt == 4'd15) begin
                        state  <= S_NEXT;
                        ram_we <= 1'b0;
                    end else begin
                        pix_cnt   <= pix_cnt + 4'd1;
                        ram_addr  <= wr_addr;
                        ram_wdata <= wr_data;
                    end
                end
                S_NEXT: begin
                    wave_cnt <= '0;
                    pix_cnt  <= '0;
                    if (row_off == LAST_OFF && col_off == LAST_OFF) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_COLLECT;
                        in_ready <= 1'b1;
                        if (int'(col_off + STEP) >= MATRIX_SIZE) begin
                            col_off <= '0;
                            row_off <= row_off + STEP;
                        end else begin
                            col_off <= col_off + STEP;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    ram_we   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_writeback.sv
// Scoreboard bench for chunk_writeback: an upstream driver feeds skewed wavefronts,
// a negedge monitor pops expected RAM writes computed from a plain image model.
module tb_chunk_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  brightness = '0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    chunk_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .brightness (brightness),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t expq[$];
    int  checks = 0;
    int  errors = 0;
    int  img[8][8];
    int  bri;
    int  wr_total = 0;
    int  acc_total = 0;
    int  busy_total = 0;
    int  done_total = 0;
    bit  abort = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int satm(input int v, input int b);
        int s;
        s = v + b;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    // Upstream diagonal pattern: lane r of wave d carries chunk pixel (r, d-3+r).
    function automatic logic [63:0] mk_wave(input int ro, input int co, input int d);
        logic [63:0] w;
        int j;
        w = '0;
        for (int r = 0; r < 4; r++) begin
            j = d - 3 + r;
            if (j >= 0 && j < 4) w[63-16*r -: 16] = 16'(img[ro+r][co+j]);
        end
        return w;
    endfunction

    task automatic build_expected();
        for (int cr = 0; cr < 2; cr++)
            for (int cc = 0; cc < 2; cc++)
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        expq.push_back('{(4*cr + i) * 8 + 4*cc + j,
                                         satm(img[4*cr+i][4*cc+j], bri)});
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                                        : int'($urandom_range(0, 300));
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 8 * r + c;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (in_valid && in_ready) acc_total++;
        if (busy) busy_total++;
        if (done) done_total++;
        if (ram_we) begin
            wr_total++;
            check("ready_low_in_write", int'(in_ready), 0);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d, no write expected", ram_addr, ram_wdata);
            end else begin
                e = expq.pop_front();
                check("wr_addr", int'(ram_addr), e.addr);
                check("wr_data", int'(ram_wdata), e.data);
            end
        end
    end

    // mode 0: valid every cycle; 1: two idle cycles before each wave; 2: random gaps
    task automatic drive_frames(input int nframes, input int mode);
        int g;
        int n;
        for (int f = 0; f < nframes; f++)
            for (int cr = 0; cr < 2; cr++)
                for (int cc = 0; cc < 2; cc++)
                    for (int d = 0; d < 7; d++) begin
                        if (mode == 0) g = 0;
                        else if (mode == 1) g = (cr == 0 && cc == 0 && d == 0) ? 0 : 2;
                        else g = int'($urandom_range(0, 2));
                        repeat (g) begin
                            in_valid = 1'b0;
                            in_data  = {$urandom, $urandom};
                            @(negedge clk);
                        end
                        in_valid = 1'b1;
                        in_data  = mk_wave(4*cr, 4*cc, d);
                        n = 0;
                        while (!in_ready && n < 400 && !abort) begin
                            @(negedge clk);
                            n++;
                        end
                        if (abort) begin
                            in_valid = 1'b0;
                            return;
                        end
                        if (n >= 400) begin
                            check("accept_timeout", n, 0);
                            in_valid = 1'b0;
                            return;
                        end
                        @(negedge clk);
                    end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done), 1);
    endtask

    task automatic start_frame(input int b);
        brightness = 9'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input int b, input int mode, input bit timed);
        int wb, ab, bb, db;
        wb = wr_total; ab = acc_total; bb = busy_total; db = done_total;
        bri = b;
        expq.delete();
        build_expected();
        start_frame(b);
        drive_frames(1, mode);
        wait_done(800);
        check("frame_writes", wr_total - wb, 64);
        check("queue_empty_at_done", expq.size(), 0);
        repeat (3) @(negedge clk);
        check("frame_accepts", acc_total - ab, 28);
        check("done_pulse_len", done_total - db, 1);
        check("busy_after_frame", int'(busy), 0);
        if (timed) check("busy_cycles", busy_total - bb, 97);
    endtask

    initial begin
        int wb, ab, n;
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, ab, n;
        // reset state, with start asserted alongside reset
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(ram_we), 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_addr", int'(ram_addr), 0);
        check("rst_wdata", int'(ram_wdata), 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // valid in IDLE is ignored
        ab = acc_total;
        in_valid = 1'b1;
        repeat (5) begin
            in_data = {$urandom, $urandom};
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("idle_no_accept", acc_total - ab, 0);
        check("idle_not_busy", int'(busy), 0);

        // ramp image, brightness 0, no gaps: addr == data, exact frame length
        fill_ramp();
        run_frame(0, 0, 1'b1);
        // same image with 1,0,0 valid toggling
        run_frame(0, 1, 1'b0);

        // saturation corners
        fill_random(); img[0][0] = 200;      img[5][6] = 200;  run_frame(100, 2, 1'b0);
        fill_random(); img[0][0] = 30;       img[7][7] = 30;   run_frame(-50, 2, 1'b0);
        fill_random(); img[0][0] = 255;      img[3][4] = 255;  run_frame(-256, 0, 1'b0);
        fill_random(); img[0][0] = 16'h0123; img[4][1] = 16'h0123; run_frame(255, 2, 1'b0);

        // random images and brightness
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_frame(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 2)), 1'b0);
        end

        // reset on the 5th write of chunk 1
        fill_random();
        bri = int'($urandom_range(0, 511)) - 256;
        expq.delete();
        build_expected();
        wb = wr_total;
        start_frame(bri);
        fork
            drive_frames(1, 2);
        join_none
        n = 0;
        while ((wr_total - wb) < 21 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reset_point_reached", wr_total - wb, 21);
        reset = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_we", int'(ram_we), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(in_ready), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        abort = 1'b0;
        expq.delete();
        @(negedge clk);
        check("abort_no_more_writes", wr_total - wb, 21);
        fill_random();
        run_frame(int'($urandom_range(0, 511)) - 256, 0, 1'b1);

        // start held high: back-to-back frames with one IDLE cycle between them
        fill_random();
        bri = int'($urandom_range(0, 511)) - 256;
        expq.delete();
        build_expected();
        build_expected();
        brightness = 9'(bri);
        start = 1'b1;
        fork
            drive_frames(2, 0);
        join_none
        wait_done(800);
        check("b2b_queue_mid", expq.size(), 64);
        @(negedge clk);
        check("b2b_idle_gap", int'(busy), 0);
        @(negedge clk);
        check("b2b_restart", int'(busy), 1);
        start = 1'b0;
        wait_done(800);
        check("b2b_queue_end", expq.size(), 0);
        repeat (3) @(negedge clk);
        check("b2b_no_third", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
